// File: rtl/shift_seq_ctrl_pkg.sv
// Shared encodings for the shift sequencer: register mode codes and controller states.
package shift_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_STORE = 2'b00,
        MODE_LOAD  = 2'b01,
        MODE_SHL   = 2'b10,
        MODE_SHR   = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_SHIFT = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    // Shift mode for a latched direction bit: 0 moves towards MSB, 1 towards LSB.
    function automatic mode_e shift_mode(input logic dir);
        shift_mode = dir ? MODE_SHR : MODE_SHL;
    endfunction

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Command and result handshakes of the shift sequencer, plus abort and busy status.
interface shift_seq_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_dir;
    logic [AMT_W-1:0] cmd_amount;
    logic [WIDTH-1:0] cmd_data;
    logic             abort;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             busy;

    modport master (
        output cmd_valid, cmd_dir, cmd_amount, cmd_data, abort, res_ready,
        input  cmd_ready, res_valid, res_data, busy
    );

    modport slave (
        input  cmd_valid, cmd_dir, cmd_amount, cmd_data, abort, res_ready,
        output cmd_ready, res_valid, res_data, busy
    );
endinterface

// File: rtl/shift_seq_ctrl_shift_reg.sv
// Parameterised shift register: hold, parallel load, or one-bit zero-filling shift per cycle.
module param_shift_reg
    import shift_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  mode_e            mode,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] q_r;

    // Register update selected by mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r <= {WIDTH{1'b0}};
        end else begin
            case (mode)
                MODE_STORE: q_r <= q_r;
                MODE_LOAD:  q_r <= data_in;
                MODE_SHL:   q_r <= {q_r[WIDTH-2:0], 1'b0};
                MODE_SHR:   q_r <= {1'b0, q_r[WIDTH-1:1]};
                default:    q_r <= q_r;
            endcase
        end
    end

    assign q = q_r;
endmodule

// File: rtl/shift_seq_ctrl.sv
// Command sequencer around param_shift_reg: load a word, shift it a commanded number
// of times, then hold it on a result handshake until consumed or aborted.
module shift_seq_ctrl
    import shift_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    shift_seq_ctrl_if.slave bus
);
    state_e           state_r;
    state_e           state_next_s;
    mode_e            mode_s;
    logic             accept_s;
    logic [AMT_W-1:0] cnt_r;
    logic             dir_r;
    logic [WIDTH-1:0] data_r;
    logic             cmd_ready_r;
    logic             res_valid_r;
    logic             busy_r;

    // Next state and register mode; abort forces store so contents stay as they are.
    always_comb begin
        state_next_s = state_r;
        mode_s       = MODE_STORE;
        accept_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cmd_ready_r && bus.cmd_valid) begin
                    accept_s     = 1'b1;
                    state_next_s = ST_LOAD;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (bus.abort) begin
                    state_next_s = ST_IDLE;
                end else begin
                    mode_s       = MODE_LOAD;
                    state_next_s = (cnt_r != {AMT_W{1'b0}}) ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                if (bus.abort) begin
                    state_next_s = ST_IDLE;
                end else begin
                    mode_s = shift_mode(dir_r);
                    if (cnt_r == AMT_W'(1)) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_SHIFT;
                    end
                end
            end
            ST_DONE: begin
                if (bus.abort || bus.res_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register with status outputs registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cmd_ready_r <= 1'b1;
            res_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            cmd_ready_r <= (state_next_s == ST_IDLE);
            res_valid_r <= (state_next_s == ST_DONE);
            busy_r      <= (state_next_s != ST_IDLE);
        end
    end

    // Command latches and shift down-counter; the counter only decrements while nonzero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= {AMT_W{1'b0}};
            dir_r  <= 1'b0;
            data_r <= {WIDTH{1'b0}};
        end else if (accept_s) begin
            cnt_r  <= bus.cmd_amount;
            dir_r  <= bus.cmd_dir;
            data_r <= bus.cmd_data;
        end else if ((state_r == ST_SHIFT) && !bus.abort && (cnt_r != {AMT_W{1'b0}})) begin
            cnt_r  <= cnt_r - AMT_W'(1);
            dir_r  <= dir_r;
            data_r <= data_r;
        end else begin
            cnt_r  <= cnt_r;
            dir_r  <= dir_r;
            data_r <= data_r;
        end
    end

    param_shift_reg #(
        .WIDTH (WIDTH)
    ) u_shift_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .mode    (mode_s),
        .data_in (data_r),
        .q       (bus.res_data)
    );

    assign bus.cmd_ready = cmd_ready_r;
    assign bus.res_valid = res_valid_r;
    assign bus.busy      = busy_r;
endmodule
